// File: rtl/vector_item_extractor.sv
// vector_item_extractor: selects one W-bit lane of a packed vector by index.
// The selection is combinational, with a registered and qualified copy alongside.
module vector_item_extractor #(
    parameter int N = 20,
    parameter int W = 10,
    localparam int AW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] vector,
    input  logic [AW-1:0]  address,
    input  logic           en,
    output logic [W-1:0]   item,
    output logic           addr_err,
    output logic [W-1:0]   item_q,
    output logic           item_valid,
    output logic           err_q
);
    logic [W-1:0] item_d;
    logic         err_d;

    // Explicit lane compare, so unselected lanes never reach item.
    always_comb begin
        item = '0;
        for (int i = 0; i < N; i++)
            if (address == AW'(i)) item = vector[i*W +: W];
    end

    assign addr_err = 32'(address) >= N;
    assign item_d   = en ? item : item_q;
    assign err_d    = en ? addr_err : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            item_q     <= '0;
            err_q      <= 1'b0;
            item_valid <= 1'b0;
        end else begin
            item_q     <= item_d;
            err_q      <= err_d;
            item_valid <= en;
        end
    end
endmodule

// File: tb/tb_vector_item_extractor.sv
// tb_vector_item_extractor: directed and random checks against a lane-array reference model.
module tb_vector_item_extractor;
    localparam int N  = 20;
    localparam int W  = 10;
    localparam int AW = $clog2(N);

    logic           clk = 0, rst_n = 0, en = 0;
    logic [N*W-1:0] vector = '0;
    logic [AW-1:0]  address = '0;
    logic [W-1:0]   item, item_q;
    logic           addr_err, item_valid, err_q;
    int             total = 0, bad = 0;
    logic [W-1:0]   lanes [N];
    logic [W-1:0]   m_q = '0;
    logic           m_err = 0, m_v = 0;

    always #5 clk = ~clk;

    vector_item_extractor #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .vector(vector), .address(address), .en(en),
        .item(item), .addr_err(addr_err), .item_q(item_q),
        .item_valid(item_valid), .err_q(err_q)
    );

    function automatic logic [W-1:0] ref_item(input int a);
        return a < N ? lanes[a] : '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic load();
        for (int i = 0; i < N; i++) vector[i*W +: W] = lanes[i];
    endtask

    task automatic comb_chk(input int a, input string tag);
        address = AW'(a);
        #1;
        chk({tag, "_item"}, 32'(item), 32'(ref_item(a)));
        chk({tag, "_err"}, 32'(addr_err), 32'(a >= N));
    endtask

    task automatic reg_chk(input string tag);
        chk({tag, "_item_q"}, 32'(item_q), 32'(m_q));
        chk({tag, "_err_q"}, 32'(err_q), 32'(m_err));
        chk({tag, "_valid"}, 32'(item_valid), 32'(m_v));
    endtask

    task automatic cyc(input logic e, input int a, input string tag);
        @(negedge clk);
        en = e;
        address = AW'(a);
        @(posedge clk);
        if (e) begin
            m_q = ref_item(a);
            m_err = a >= N;
        end
        m_v = e;
        #1;
        reg_chk(tag);
    endtask

    initial begin
        for (int i = 0; i < N; i++) lanes[i] = '0;
        lanes[0] = 50; lanes[1] = 51; lanes[2] = 52; lanes[3] = 35;
        load();
        en = 1;
        address = 2;
        #2;
        reg_chk("rst_async");
        repeat (2) @(posedge clk);
        #1;
        reg_chk("rst_held");
        for (int a = 0; a < 4; a++) begin
            comb_chk(a, "lane");
            #9;
        end
        lanes[19] = '1;
        load();
        comb_chk(19, "lane19");
        comb_chk(20, "oor20");
        comb_chk(31, "oor31");
        @(negedge clk);
        en = 0;
        rst_n = 1;
        cyc(1, 2, "pulse");
        cyc(0, 2, "hold");
        for (int a = 0; a < 4; a++) cyc(1, a, "b2b");
        cyc(1, 25, "b2b_oor");
        cyc(1, 1, "pre_rst");
        #2;
        rst_n = 0;
        m_q = '0; m_err = 0; m_v = 0;
        #1;
        reg_chk("mid_rst");
        comb_chk(3, "rst_comb");
        @(negedge clk);
        en = 0;
        rst_n = 1;
        cyc(0, 0, "post_rst");
        cyc(1, 3, "post_cap");
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++) lanes[i] = W'($urandom);
                load();
            end
            comb_chk(int'($urandom_range(0, 31)), "rnd_comb");
            cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), "rnd_reg");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
